// File: rtl/i2s_sample_tx.sv
// i2s_sample_tx: serial audio transmitter for the synth output.
// Accepts mono samples from the mixer over a valid/ready handshake into a
// single-entry holding buffer. Each sample is shifted out MSB first on both
// the left and right slots of a left-justified stereo frame (bclk, lrclk, sdata).
// If a frame starts with an empty buffer, the last sample is repeated, a
// one-clk underrun pulse is raised, and a saturating counter is bumped.
module i2s_sample_tx #(
  parameter int unsigned CLK_DIV = 2,   // clk cycles per bclk half-period, >= 1
  parameter int unsigned SAMP_W  = 16   // sample width and bits per channel slot
) (
  input  logic              clk,
  input  logic              reset,        // asynchronous, active low
  input  logic [SAMP_W-1:0] samp_in,
  input  logic              samp_valid,
  output logic              samp_ready,
  output logic              bclk,
  output logic              lrclk,
  output logic              sdata,
  output logic              underrun,
  output logic [7:0]        underrun_cnt
);

  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned SLOT_W = $clog2(2 * SAMP_W);

  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(2 * SAMP_W - 1);
  localparam logic [SLOT_W-1:0] SLOT_RIGHT = SLOT_W'(SAMP_W);
  localparam logic [7:0]        CNT_MAX    = 8'hFF;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0]  div_q,     div_d;
  logic              bclk_q,    bclk_d;
  logic [SLOT_W-1:0] slot_q,    slot_d;
  logic              started_q, started_d;   // a first frame has begun since reset
  logic              lrclk_q,   lrclk_d;
  logic              sdata_q,   sdata_d;
  logic [SAMP_W-1:0] shift_q,   shift_d;
  logic [SAMP_W-1:0] hold_q,    hold_d;      // single-entry holding buffer
  logic              full_q,    full_d;
  logic              ready_q,   ready_d;
  logic [SAMP_W-1:0] last_q,    last_d;      // sample of the current frame
  logic              underrun_q,     underrun_d;
  logic [7:0]        underrun_cnt_q, underrun_cnt_d;

  // ---------------------------------------------------------------------------
  // Event decode
  // ---------------------------------------------------------------------------
  logic              div_tick;     // divider wraps, bclk toggles this edge
  logic              fall;         // bclk 1->0 on this edge: serial outputs advance
  logic              frame_start;  // falling event that opens slot 0
  logic              accept;       // handshake completes this edge
  logic [SLOT_W-1:0] slot_nxt;     // slot that begins on this falling event
  logic [SAMP_W-1:0] frame_samp;   // sample chosen at frame start

  assign div_tick    = (div_q == DIV_LAST);
  assign fall        = div_tick && bclk_q;
  assign frame_start = fall && (!started_q || (slot_q == SLOT_LAST));
  assign accept      = samp_valid && ready_q;
  assign slot_nxt    = frame_start ? '0 : slot_q + 1'b1;
  assign frame_samp  = full_q ? hold_q : last_q;

  // Bit-clock divider: count 0..CLK_DIV-1, toggle bclk on wrap.
  // NOTE: every combinational block assigns each output a default first,
  // so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    div_d  = div_tick ? '0 : div_q + 1'b1;
    bclk_d = div_tick ? ~bclk_q : bclk_q;
  end

  // Slot sequencing and serializer: all serial outputs move on falling events.
  always_comb begin
    slot_d    = slot_q;
    started_d = started_q;
    lrclk_d   = lrclk_q;
    sdata_d   = sdata_q;
    shift_d   = shift_q;
    if (fall) begin
      slot_d    = slot_nxt;
      started_d = 1'b1;
      lrclk_d   = (slot_nxt >= SLOT_RIGHT);
      if (frame_start) begin
        // Left half begins: serialize the newly chosen frame sample.
        sdata_d = frame_samp[SAMP_W-1];
        shift_d = frame_samp << 1;
      end else if (slot_nxt == SLOT_RIGHT) begin
        // Right half begins: reload the same sample from the frame register.
        sdata_d = last_q[SAMP_W-1];
        shift_d = last_q << 1;
      end else begin
        sdata_d = shift_q[SAMP_W-1];
        shift_d = shift_q << 1;
      end
    end
  end

  // Holding buffer, handshake and frame-start sample selection.
  always_comb begin
    hold_d = hold_q;
    full_d = full_q;
    last_d = last_q;
    if (frame_start && full_q) begin
      // Buffer drains into the frame; ready is low so no accept can coincide.
      last_d = hold_q;
      full_d = 1'b0;
    end else if (accept) begin
      // Also covers an accept on an empty-buffer frame start: the frame
      // repeats last_q and the new sample waits for the next frame.
      hold_d = samp_in;
      full_d = 1'b1;
    end
    ready_d = ~full_d;
  end

  // Underrun flag and saturating underrun counter.
  always_comb begin
    underrun_d     = frame_start && !full_q;
    underrun_cnt_d = underrun_cnt_q;
    if (underrun_d && (underrun_cnt_q != CNT_MAX)) begin
      underrun_cnt_d = underrun_cnt_q + 8'd1;
    end
  end

  // State registers; reset aborts any frame in progress.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q          <= '0;
      bclk_q         <= 1'b0;
      slot_q         <= '0;
      started_q      <= 1'b0;
      lrclk_q        <= 1'b0;
      sdata_q        <= 1'b0;
      shift_q        <= '0;
      // NOTE: the holding buffer and frame sample are data registers but are
      // cleared here because an underrun right after reset must send zeros.
      hold_q         <= '0;
      last_q         <= '0;
      full_q         <= 1'b0;
      ready_q        <= 1'b1;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= '0;
    end else begin
      div_q          <= div_d;
      bclk_q         <= bclk_d;
      slot_q         <= slot_d;
      started_q      <= started_d;
      lrclk_q        <= lrclk_d;
      sdata_q        <= sdata_d;
      shift_q        <= shift_d;
      hold_q         <= hold_d;
      last_q         <= last_d;
      full_q         <= full_d;
      ready_q        <= ready_d;
      underrun_q     <= underrun_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  assign samp_ready   = ready_q;
  assign bclk         = bclk_q;
  assign lrclk        = lrclk_q;
  assign sdata        = sdata_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = underrun_cnt_q;

endmodule

// File: doc/i2s_sample_tx.md
Name: i2s_sample_tx

Overview:
- Serial audio transmitter at the output end of the synth datapath: accepts 16-bit mixed samples from mix4 through a valid/ready handshake and shifts them out as a left-justified, I2S-style stereo stream (bclk, lrclk, sdata) toward an external DAC.
- The mono sample is sent on both left and right slots.
- Single-entry holding buffer decouples the mixer's sample rate from the frame rate.
- Underruns repeat the last sample, are flagged, and are counted.

Parameters:
- CLK_DIV, 2, clk cycles per bclk half-period (>=1).
- SAMP_W, 16, sample width and bits per channel slot.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- samp_in  input  SAMP_W  sample data, two's complement (mixer samp_out).
- samp_valid  input  1  samp_in is valid.
- samp_ready  output  1  holding buffer empty; transfer occurs when samp_valid && samp_ready at a clk edge.
- bclk  output  1  serial bit clock.
- lrclk  output  1  channel select: 0 = left slot, 1 = right slot.
- sdata  output  1  serial data, MSB first, changes only on bclk falling edge.
- underrun  output  1  one-clk pulse when a frame starts with an empty buffer.
- underrun_cnt  output  8  saturating count of underruns.

Behaviour:
- Reset (reset low, asynchronous): bclk=0, lrclk=0, sdata=0, samp_ready=1, underrun=0, underrun_cnt=0.
  - Also cleared: div counter, slot counter, holding buffer, full flag, shift register, last-sample register.
  - Reset asserted mid-frame aborts the frame immediately. No partial bits resume after release.
- Divider: div_cnt counts 0..CLK_DIV-1. At CLK_DIV-1 it wraps and bclk toggles. bclk period = 2*CLK_DIV clk.
- Falling event = cycle on which bclk toggles 1->0. All serial outputs update on that clk edge.
  - The first falling event after reset occurs 2*CLK_DIV clk edges after release.
- Slot counter: slot counts 0..2*SAMP_W-1 and advances on each falling event.
  - The first falling event after reset starts slot 0 (frame start).
  - slot wraps from 2*SAMP_W-1 to 0, which is a frame start.
- lrclk = 0 for slots 0..SAMP_W-1 and 1 for slots SAMP_W..2*SAMP_W-1. It updates on the same edge as sdata; no one-bit I2S delay (left-justified).
- sdata in slot k = bit (SAMP_W-1 - (k mod SAMP_W)) of the frame sample. Both halves carry the same sample.
- Frame period = 4*SAMP_W*CLK_DIV clk cycles (128 with defaults).
- Frame start load:
  - If full=1: the frame sample is the holding buffer; last <= holding; full <= 0.
  - If full=0: the frame sample is last; underrun pulses high for exactly one clk; underrun_cnt increments, saturating at 255.
- Handshake:
  - samp_ready = ~full, driven from a register; no combinational path from samp_valid.
  - On accept: holding <= samp_in and full <= 1, so samp_ready goes low on the next cycle.
  - samp_in is ignored while samp_ready=0.
- Simultaneous accept and frame start with full=0: the frame uses last and underrun fires. The accepted sample goes to holding and is sent in the next frame.
- Frame start with full=1: no accept can happen that cycle because ready=0. Ready rises the following cycle.
- The holding buffer is never overwritten while full. Samples are never dropped and never duplicated, except on underrun repeat.

Test Plan:
- Reset check: hold reset low 3 clk, then release → all outputs at reset values. First bclk rise at clk edge 2 after release, first fall at edge 4 (CLK_DIV=2). lrclk=0 and sdata=MSB of 0 for slot 0 of frame 0; underrun pulses at that edge, underrun_cnt=1.
- Single sample: present 16'hA5C3 with valid before the first frame start → left slots sample sdata as 1010010111000011 on bclk rising edges, and the right slots repeat the same bits. lrclk high for exactly 16 bclk periods per frame; frame = 128 clk.
- Back-to-back: keep valid high with 16'h8001, 16'h7FFE, 16'hFFFF → ready drops after each accept and rises only after a frame start. Each sample appears in order in consecutive frames with no underrun.
- Underrun: after sending 16'h1234, supply nothing for 3 frames → 16'h1234 repeats each frame. underrun pulses 3 times, each one clk wide, and underrun_cnt increments by 3.
- Collision: assert valid with 16'h00FF on exactly the clk edge of a frame start while the buffer is empty → that frame carries the previous sample and underrun fires. 16'h00FF is sent in the following frame.
- Saturation and mid-frame reset: force 300 underruns → underrun_cnt=255. Then pulse reset at slot 7 → outputs return to reset values immediately and the counter reads 0.
